async_fifo_gray: RTL
====================

// Module: async_fifo_gray
// PURPOSE
//  Dual-clock FIFO, next generation of the team FIFO: power-of-two depth, Gray-coded pointers crossing via
//  multi-flop synchronisers, programmable almost-full/almost-empty thresholds, per-domain fill levels and
//  overflow/underflow pulses. Sits between any producer on write_clock and consumer on read_clock.
// PARAMETERS
//  DATA_WIDTH      32  word width
//  ADDR_WIDTH      3   DEPTH = 2**ADDR_WIDTH entries (min 2)
//  SYNC_STAGES     2   flops per pointer synchroniser (min 2)
//  AF_THRESH       6   almost_full when write_level >= AF_THRESH (1..DEPTH)
//  AE_THRESH       2   almost_empty when read_level <= AE_THRESH (0..DEPTH-1)
// PORTS
//  write_clock   in   1             write-domain clock
//  reset         in   1             async active-high, clears both domains
//  read_clock    in   1             read-domain clock
//  data          in   DATA_WIDTH    write data
//  write_enable  in   1             write request
//  fifo_full     out  1             write domain; writes ignored while 1
//  almost_full   out  1             write domain
//  write_level   out  ADDR_WIDTH+1  write-domain occupancy, 0..DEPTH
//  overflow      out  1             1-cycle pulse: write_enable while fifo_full
//  read_enable   in   1             read request
//  q             out  DATA_WIDTH    read data
//  fifo_empty    out  1             read domain; reads ignored while 1
//  almost_empty  out  1             read domain
//  read_level    out  ADDR_WIDTH+1  read-domain occupancy, 0..DEPTH
//  underflow     out  1             1-cycle pulse: read_enable while fifo_empty
// BEHAVIOUR
//  Reset (async assert, both domains): pointers/synchronisers 0, fifo_full 0, fifo_empty 1, almost_full 0,
//   almost_empty 1, levels 0, q 0, overflow/underflow 0. Memory not reset. Deassertion synchronised upstream
//   to each clock; reset mid-transfer discards all contents, no partial state survives.
//  Pointers: ADDR_WIDTH+1-bit binary + registered Gray copy per domain; extra MSB distinguishes full from
//   empty on wrap-around. Only Gray values cross domains.
//  Write: posedge write_clock, write_enable & ~fifo_full -> mem[wptr[ADDR_WIDTH-1:0]] <= data, wptr++.
//   write_enable & fifo_full -> write dropped, memory/pointers unchanged, overflow=1 next cycle.
//  Read: posedge read_clock, read_enable & ~fifo_empty -> q <= mem[rptr[ADDR_WIDTH-1:0]], rptr++;
//   q valid immediately after that edge. read_enable & fifo_empty -> q holds, underflow=1 next cycle.
//  fifo_full registered: set when next wgray == {~rsync[MSB:MSB-1], rsync[rest]}; deasserts SYNC_STAGES+1
//   write cycles after the freeing read. fifo_empty registered: next rgray == wsync; first written word
//   visible after SYNC_STAGES+1 read cycles.
//  Levels: write_level = wptr - gray2bin(rsync) (pessimistic, never under-reports); read_level =
//   gray2bin(wsync) - rptr (never over-reports). Mod 2**(ADDR_WIDTH+1) arithmetic.
//  almost_full/almost_empty registered from next-state level each edge; consistent with full/empty
//   (full implies almost_full, empty implies almost_empty).
//  Simultaneous read and write: independent domains, both proceed; no data lost or duplicated.
// STRUCTURE
//  fifo_pkg: functions bin2gray/gray2bin, parameter-check constants (DEPTH, LEVEL_W).
//  Sub-module ptr_sync: SYNC_STAGES-deep Gray pointer synchroniser with async reset, instantiated twice.
//  Memory: plain reg array, write port on write_clock, registered read on read_clock.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=3, write 10 ns, read 14 ns, defaults otherwise)
//  Reset then idle -> fifo_empty=1, almost_empty=1, fifo_full=0, q=0, levels=0.
//  Write 0x01..0x08 -> fifo_full=1 after 8th; almost_full=1 from 6th; 9th write 0xFF -> overflow pulse,
//   then read all 8 -> q=0x01..0x08 in order, fifo_empty=1, no 0xFF.
//  Read on empty -> underflow pulse, q unchanged, rptr unchanged.
//  Continuous write+read 1000 random words across >100 wraps -> output sequence identical, no full/empty error.
//  Single write 0xA5 into empty -> fifo_empty drops within SYNC_STAGES+1 read edges, read gives q=0xA5.
//  Assert reset with 5 words stored, mid-read -> all outputs at reset values, next write/read returns new data only.

Source files
------------

// File: rtl/async_fifo_gray_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | async_fifo_gray_pkg : Gray-code helpers and size constants   Rev 1.0     |
// +--------------------------------------------------------------------------+
package async_fifo_gray_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra pointer bit separates full from empty after wrap-around.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended inputs are safe: leading zero Gray bits decode to zero.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/async_fifo_gray_ptr_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | async_fifo_gray_ptr_sync : multi-flop Gray pointer synchroniser  Rev 1.0 |
// +--------------------------------------------------------------------------+
module async_fifo_gray_ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/async_fifo_gray.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | async_fifo_gray : dual-clock Gray-pointer FIFO with levels/flags Rev 1.0 |
// +--------------------------------------------------------------------------+
module async_fifo_gray
  import async_fifo_gray_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6,
  parameter int AE_THRESH   = 2
) (
  input  logic                  write_clock,
  input  logic                  reset,
  input  logic                  read_clock,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  write_enable,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   write_level,
  output logic                  overflow,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  fifo_empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   read_level,
  output logic                  underflow
);

  localparam int PTR_W   = ADDR_WIDTH + 1;
  localparam int DEPTH   = depth_of(ADDR_WIDTH);
  localparam int LEVEL_W = level_width(ADDR_WIDTH);

  // Full when the write Gray pointer equals the read one with its top two bits inverted.
  localparam logic [PTR_W-1:0]   FULL_MASK = PTR_W'(3) << (PTR_W - 2);
  localparam logic [LEVEL_W-1:0] AF_LEVEL  = LEVEL_W'(AF_THRESH);
  localparam logic [LEVEL_W-1:0] AE_LEVEL  = LEVEL_W'(AE_THRESH);

  function automatic logic [PTR_W-1:0] to_gray(input logic [PTR_W-1:0] bin);
    ptr_word_t g;
    g = bin2gray(ptr_word_t'(bin));
    return g[PTR_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] to_bin(input logic [PTR_W-1:0] gray);
    ptr_word_t b;
    b = gray2bin(ptr_word_t'(gray));
    return b[PTR_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]   wbin, wgray, wbin_next, wgray_next, rsync, rsync_bin;
  logic [PTR_W-1:0]   rbin, rgray, rbin_next, rgray_next, wsync, wsync_bin;
  logic [LEVEL_W-1:0] wlevel_next, rlevel_next;
  logic               write_fire, read_fire, full_next, empty_next;

  async_fifo_gray_ptr_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rptr_sync (
    .clk   (write_clock),
    .reset (reset),
    .d     (rgray),
    .q     (rsync)
  );

  async_fifo_gray_ptr_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wptr_sync (
    .clk   (read_clock),
    .reset (reset),
    .d     (wgray),
    .q     (wsync)
  );

  // Write domain: level measured against a stale read pointer, so it errs high.
  assign write_fire  = write_enable & ~fifo_full;
  assign wbin_next   = wbin + PTR_W'(write_fire);
  assign wgray_next  = to_gray(wbin_next);
  assign rsync_bin   = to_bin(rsync);
  assign full_next   = (wgray_next == (rsync ^ FULL_MASK));
  assign wlevel_next = wbin_next - rsync_bin;

  always_ff @(posedge write_clock or posedge reset) begin
    if (reset) begin
      wbin        <= '0;
      wgray       <= '0;
      fifo_full   <= 1'b0;
      almost_full <= 1'b0;
      write_level <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      fifo_full   <= full_next;
      almost_full <= (wlevel_next >= AF_LEVEL);
      write_level <= wlevel_next;
      overflow    <= write_enable & fifo_full;
    end
  end

  always_ff @(posedge write_clock) begin
    if (write_fire) begin
      mem[wbin[ADDR_WIDTH-1:0]] <= data;
    end
  end

  // Read domain: level measured against a stale write pointer, so it errs low.
  assign read_fire   = read_enable & ~fifo_empty;
  assign rbin_next   = rbin + PTR_W'(read_fire);
  assign rgray_next  = to_gray(rbin_next);
  assign wsync_bin   = to_bin(wsync);
  assign empty_next  = (rgray_next == wsync);
  assign rlevel_next = wsync_bin - rbin_next;

  always_ff @(posedge read_clock or posedge reset) begin
    if (reset) begin
      rbin         <= '0;
      rgray        <= '0;
      q            <= '0;
      fifo_empty   <= 1'b1;
      almost_empty <= 1'b1;
      read_level   <= '0;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rgray        <= rgray_next;
      if (read_fire) begin
        q <= mem[rbin[ADDR_WIDTH-1:0]];
      end
      fifo_empty   <= empty_next;
      almost_empty <= (rlevel_next <= AE_LEVEL);
      read_level   <= rlevel_next;
      underflow    <= read_enable & fifo_empty;
    end
  end

endmodule
`default_nettype wire
